ddr_cmd_scheduler: RTL
======================

Name: ddr_cmd_scheduler

Overview:
- Controller-side sequencer that turns single-access read/write requests into legal DDR4 command streams (ACT/RD/WR/PR/PRA/REF) for the emulated DIMM.
- Tracks the open row per bank, enforces tRCD/tRP/tRAS/tCCD/tRFC with counters, and inserts periodic refresh.
- Drives the DIMM command pins plus one-hot command strobes for the timing model.

Parameters:
- TRCD, 4, cycles from ACT to first RD/WR on that bank
- TRP, 4, cycles from PR/PRA to next ACT or REF
- TRAS, 10, minimum cycles from ACT to PR on the same bank
- TCCD, 2, minimum cycles between column commands (RD/WR)
- TRFC, 20, cycles from REF to next command
- TREFI, 400, cycles between refresh requests

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- req_valid  in  1  request present
- req_ready  out  1  request accepted when valid&ready
- req_we  in  1  1=write, 0=read
- req_bg  in  2  bank group
- req_ba  in  2  bank
- req_row  in  17  row address
- req_col  in  10  column address
- act_n  out  1  DDR4 ACT_n
- cs_n  out  1  chip select, active low
- adr  out  17  A16..A0 (A16=RAS_n, A15=CAS_n, A14=WE_n when act_n=1)
- ba  out  2  bank address
- bg  out  2  bank group
- par  out  1  command parity
- ACT, RD, WR, PR, PRA, REF  out  1 each  one-cycle command strobes
- busy  out  1  FSM not in IDLE

Behaviour:
- All outputs registered. Reset: cs_n=1, act_n=1, adr=0, ba=0, bg=0, par=0, strobes=0, req_ready=0, busy=0; all banks closed, all counters 0, refresh_pending=0.
- Idle cycle (no command): cs_n=1, strobes 0, other pins hold last value.
- Encodings (cs_n=0): ACT act_n=0, adr=row. RD act_n=1, A16..A14=1,0,1, adr[9:0]=col, A10=0. WR 1,0,0. PR 0,1,0, A10=0. PRA 0,1,0, A10=1. REF 0,0,1.
- Bank state table: 16 entries indexed {bg,ba}: open bit, 17-bit row, tRAS down-counter (loaded TRAS-1 on ACT).
- Global wait counter (tRCD/tRP/tRFC) and tCCD counter; each counts down to 0 and saturates.
- Refresh timer counts TREFI cycles; at terminal count sets refresh_pending (single flag; further expiries while pending are not queued); timer restarts every TREFI regardless.
- FSM states: IDLE, PRE, WAIT_RP, ACTV, WAIT_RCD, COL, RPRA, RWAIT_RP, RREF, RWAIT_RFC.
- IDLE: req_ready=1 only in IDLE and when refresh_pending=0. refresh_pending has priority over a simultaneous req_valid (request not accepted). On accept, latch request; hit (open, row match) -> COL; closed -> ACTV; conflict (open, row differs) -> PRE.
- PRE: wait until bank tRAS counter=0, issue PR one cycle, clear open bit, load TRP-1 -> WAIT_RP -> ACTV when counter=0.
- ACTV: issue ACT, set open/row, load TRCD-1 -> WAIT_RCD -> COL when counter=0.
- COL: wait until tCCD counter=0, issue RD or WR, load TCCD-1 -> IDLE.
- Refresh: RPRA waits until all open banks have tRAS=0, issues PRA, clears all open bits (skip PRA if no bank open, go directly to RREF); RWAIT_RP TRP; RREF issues REF, clears refresh_pending; RWAIT_RFC TRFC -> IDLE.
- Minimum request latency: hit = accept + 1 cycle to RD/WR; closed = ACT then column command TRCD cycles later.
- Reset mid-sequence aborts immediately to reset state; no partial commands.

Optional Feature:
- CMD_PARITY_EN: defined -> par = even parity (XOR) over act_n, adr[16:0], bg, ba on every cs_n=0 cycle, registered with the command; undefined -> par tied 0.

Test Plan:
- Read to closed bank bg=1,ba=2,row=0x123,col=0x40 -> ACT (adr=0x00123) at t, RD (adr A16..A14=101, col=0x040) at t+4; busy low after.
- Write hit same row col=0x41 immediately after -> WR issued ≥2 cycles after prior RD (tCCD), no ACT.
- Conflict row=0x124 same bank 3 cycles after ACT -> PR held until 10 cycles post-ACT, ACT 4 cycles after PR, WR 4 after ACT.
- Run to 400 cycles with two banks open -> PRA with A10=1, REF 4 cycles later, no command for 20 cycles, req_ready=0 throughout.
- req_valid asserted same cycle refresh_pending sets -> request not accepted until after tRFC; then serviced with ACT (banks closed by PRA).
- Assert rst during WAIT_RCD -> cs_n=1, strobes 0, busy 0 immediately; next request to same bank issues ACT (table cleared).

Source files
------------

// File: rtl/ddr_cmd_scheduler_if.sv
// Request channel into the DDR4 command scheduler: one single-beat read or
// write per valid/ready handshake, addressed by bank group, bank, row and column.
interface ddr_cmd_scheduler_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_bg;
  logic [1:0]  req_ba;
  logic [16:0] req_row;
  logic [9:0]  req_col;

  modport master (
    output req_valid, req_we, req_bg, req_ba, req_row, req_col,
    input  req_ready
  );

  modport slave (
    input  req_valid, req_we, req_bg, req_ba, req_row, req_col,
    output req_ready
  );
endinterface

// File: rtl/ddr_cmd_scheduler.sv
// DDR4 command sequencer: open-row tracking per bank, tRCD/tRP/tRAS/tCCD/tRFC
// timing and periodic refresh. Define CMD_PARITY_EN to drive even command parity.
module ddr_cmd_scheduler #(
  parameter int TRCD  = 4,
  parameter int TRP   = 4,
  parameter int TRAS  = 10,
  parameter int TCCD  = 2,
  parameter int TRFC  = 20,
  parameter int TREFI = 400
) (
  input  logic                  clk,
  input  logic                  rst,
  ddr_cmd_scheduler_if.slave    req,
  output logic                  act_n,
  output logic                  cs_n,
  output logic [16:0]           adr,
  output logic [1:0]            ba,
  output logic [1:0]            bg,
  output logic                  par,
  output logic                  ACT,
  output logic                  RD,
  output logic                  WR,
  output logic                  PR,
  output logic                  PRA,
  output logic                  REF,
  output logic                  busy
);

  localparam int T_A   = (TRAS > TRFC) ? TRAS : TRFC;
  localparam int T_B   = (TRCD > TRP) ? TRCD : TRP;
  localparam int T_C   = (T_A > T_B) ? T_A : T_B;
  localparam int T_MAX = (T_C > TCCD) ? T_C : TCCD;
  localparam int CNT_W  = $clog2(T_MAX + 1);
  localparam int REFI_W = $clog2(TREFI);

  localparam logic [CNT_W-1:0]  LD_RCD    = CNT_W'(TRCD - 1);
  localparam logic [CNT_W-1:0]  LD_RP     = CNT_W'(TRP - 1);
  localparam logic [CNT_W-1:0]  LD_RAS    = CNT_W'(TRAS - 1);
  localparam logic [CNT_W-1:0]  LD_CCD    = CNT_W'(TCCD - 1);
  localparam logic [CNT_W-1:0]  LD_RFC    = CNT_W'(TRFC - 1);
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
  localparam logic [REFI_W-1:0] REFI_LAST = REFI_W'(TREFI - 1);

  typedef enum logic [3:0] {
    IDLE, PRE, WAIT_RP, ACTV, WAIT_RCD, COL, RPRA, RWAIT_RP, RREF, RWAIT_RFC
  } state_e;

  typedef enum logic [2:0] {
    C_NONE, C_ACT, C_RD, C_WR, C_PR, C_PRA, C_REF
  } cmd_e;

  state_e state, state_nxt;
  cmd_e   cmd;
  logic   accept;

  logic [15:0]      bank_open;
  logic [16:0]      bank_row [16];
  logic [CNT_W-1:0] tras_cnt [16];
  logic [CNT_W-1:0] wait_cnt;
  logic [CNT_W-1:0] tccd_cnt;
  logic [REFI_W-1:0] refi_cnt;
  logic             refresh_pending, rp_nxt;

  logic        lat_we;
  logic [1:0]  lat_bg, lat_ba;
  logic [16:0] lat_row;
  logic [9:0]  lat_col;
  logic [3:0]  lat_idx, req_idx;

  logic        cmd_act_n, cmd_par, tras_all_zero;
  logic [16:0] cmd_adr;
  logic [1:0]  cmd_bg, cmd_ba;

  function automatic logic [CNT_W-1:0] sat_dec(input logic [CNT_W-1:0] c);
    return (c == '0) ? c : c - CNT_ONE;
  endfunction

  assign lat_idx = {lat_bg, lat_ba};
  assign req_idx = {req.req_bg, req.req_ba};

  always_comb begin
    tras_all_zero = 1'b1;
    for (int i = 0; i < 16; i++)
      if (bank_open[i] && tras_cnt[i] != '0) tras_all_zero = 1'b0;
  end

  // Wait states leave one cycle early so the issuing state acts on the cycle the counter reaches 0.
  always_comb begin
    state_nxt = state;
    cmd       = C_NONE;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        if (refresh_pending) begin
          state_nxt = RPRA;
        end else if (req.req_valid && req.req_ready) begin
          accept = 1'b1;
          if (!bank_open[req_idx])                 state_nxt = ACTV;
          else if (bank_row[req_idx] == req.req_row) state_nxt = COL;
          else                                     state_nxt = PRE;
        end
      end
      PRE: begin
        if (tras_cnt[lat_idx] == '0) begin
          cmd       = C_PR;
          state_nxt = WAIT_RP;
        end
      end
      WAIT_RP:   if (wait_cnt <= CNT_ONE) state_nxt = ACTV;
      ACTV: begin
        cmd       = C_ACT;
        state_nxt = WAIT_RCD;
      end
      WAIT_RCD:  if (wait_cnt <= CNT_ONE) state_nxt = COL;
      COL: begin
        if (tccd_cnt == '0) begin
          cmd       = lat_we ? C_WR : C_RD;
          state_nxt = IDLE;
        end
      end
      RPRA: begin
        if (bank_open == '0) begin
          state_nxt = RREF;
        end else if (tras_all_zero) begin
          cmd       = C_PRA;
          state_nxt = RWAIT_RP;
        end
      end
      RWAIT_RP:  if (wait_cnt <= CNT_ONE) state_nxt = RREF;
      RREF: begin
        cmd       = C_REF;
        state_nxt = RWAIT_RFC;
      end
      RWAIT_RFC: if (wait_cnt <= CNT_ONE) state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  always_comb begin
    cmd_act_n = 1'b1;
    cmd_adr   = '0;
    cmd_bg    = lat_bg;
    cmd_ba    = lat_ba;
    case (cmd)
      C_ACT: begin
        cmd_act_n = 1'b0;
        cmd_adr   = lat_row;
      end
      C_RD:  cmd_adr = {3'b101, 4'b0000, lat_col};
      C_WR:  cmd_adr = {3'b100, 4'b0000, lat_col};
      C_PR:  cmd_adr = {3'b010, 14'h0000};
      C_PRA: begin
        cmd_adr = {3'b010, 3'b000, 1'b1, 10'h000};
        cmd_bg  = 2'b00;
        cmd_ba  = 2'b00;
      end
      C_REF: begin
        cmd_adr = {3'b001, 14'h0000};
        cmd_bg  = 2'b00;
        cmd_ba  = 2'b00;
      end
      default: ;
    endcase
  end

`ifdef CMD_PARITY_EN
  assign cmd_par = ^{cmd_act_n, cmd_adr, cmd_bg, cmd_ba};
`else
  assign cmd_par = 1'b0;
`endif

  // A timer expiry on the same cycle as REF re-arms the flag rather than being lost.
  assign rp_nxt = (refi_cnt == REFI_LAST) || (refresh_pending && cmd != C_REF);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= IDLE;
      cs_n            <= 1'b1;
      act_n           <= 1'b1;
      adr             <= '0;
      ba              <= '0;
      bg              <= '0;
      par             <= 1'b0;
      {ACT, RD, WR, PR, PRA, REF} <= '0;
      busy            <= 1'b0;
      req.req_ready   <= 1'b0;
      bank_open       <= '0;
      for (int i = 0; i < 16; i++) tras_cnt[i] <= '0;
      wait_cnt        <= '0;
      tccd_cnt        <= '0;
      refi_cnt        <= '0;
      refresh_pending <= 1'b0;
    end else begin
      state           <= state_nxt;
      cs_n            <= (cmd == C_NONE);
      {ACT, RD, WR, PR, PRA, REF} <= {cmd == C_ACT, cmd == C_RD, cmd == C_WR,
                                      cmd == C_PR, cmd == C_PRA, cmd == C_REF};
      if (cmd != C_NONE) begin
        act_n <= cmd_act_n;
        adr   <= cmd_adr;
        bg    <= cmd_bg;
        ba    <= cmd_ba;
        par   <= cmd_par;
      end
      busy            <= (state_nxt != IDLE);
      req.req_ready   <= (state_nxt == IDLE) && !rp_nxt;
      refresh_pending <= rp_nxt;
      refi_cnt        <= (refi_cnt == REFI_LAST) ? '0 : refi_cnt + REFI_W'(1);

      for (int i = 0; i < 16; i++) begin
        if (cmd == C_ACT && lat_idx == 4'(i)) tras_cnt[i] <= LD_RAS;
        else                                  tras_cnt[i] <= sat_dec(tras_cnt[i]);
      end

      case (cmd)
        C_ACT:   bank_open[lat_idx] <= 1'b1;
        C_PR:    bank_open[lat_idx] <= 1'b0;
        C_PRA:   bank_open          <= '0;
        default: ;
      endcase

      case (cmd)
        C_ACT:        wait_cnt <= LD_RCD;
        C_PR, C_PRA:  wait_cnt <= LD_RP;
        C_REF:        wait_cnt <= LD_RFC;
        default:      wait_cnt <= sat_dec(wait_cnt);
      endcase

      tccd_cnt <= (cmd == C_RD || cmd == C_WR) ? LD_CCD : sat_dec(tccd_cnt);
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      lat_we  <= req.req_we;
      lat_bg  <= req.req_bg;
      lat_ba  <= req.req_ba;
      lat_row <= req.req_row;
      lat_col <= req.req_col;
    end
    if (cmd == C_ACT) bank_row[lat_idx] <= lat_row;
  end

endmodule
